// File: rtl/busenc_pkg.sv
// Shared constants and helpers for the encoded-bus arbiter.
// Channel codes, default widths and a population count.
package busenc_pkg;

    localparam logic CH_ADDR = 1'b0;
    localparam logic CH_DATA = 1'b1;

    localparam int W_DEF  = 8;
    localparam int CW_DEF = 16;

    localparam int POP_MAX = 64;

    // Number of set bits in a vector of up to POP_MAX bits.
    function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < POP_MAX; i++) begin
            c = c + {31'b0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/hamdist.sv
// Combinational Hamming distance between two N-bit words.
// Used both for the bus-invert decision and for toggle counting.
module hamdist
    import busenc_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]             a_i,
    input  logic [N-1:0]             b_i,
    output logic [$clog2(N+1)-1:0]   dist_o
);

    localparam int DW = $clog2(N + 1);

    logic [POP_MAX-1:0] diff;

    // Zero-extend the XOR so the shared popcount can be reused.
    always_comb begin
        diff         = '0;
        diff[N-1:0]  = a_i ^ b_i;
    end

    assign dist_o = DW'(popcount(diff));

endmodule

// File: rtl/busarb_encctl.sv
// Two-channel arbiter for a shared low-power bus.
// Address beats use T0 freeze, data beats use bus-invert.
module busarb_encctl
    import busenc_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int CW     = CW_DEF,
    parameter int STRIDE = 1
) (
    input  logic          ck,
    input  logic          rst,
    input  logic          a_valid,
    input  logic [W-1:0]  a_data,
    output logic          a_ready,
    input  logic          d_valid,
    input  logic [W-1:0]  d_data,
    output logic          d_ready,
    output logic [W-1:0]  bus,
    output logic          bus_inv,
    output logic          bus_inc,
    output logic          bus_sel,
    output logic          bus_vld,
    input  logic          clr_cnt,
    output logic [CW-1:0] trans_cnt
);

    localparam int HW = $clog2(W + 1);
    localparam int TW = $clog2(W + 3);
    localparam int SW = CW + TW;

    localparam logic [W-1:0]  STEP = W'(STRIDE);
    localparam logic [HW-1:0] HALF = HW'(W / 2);
    localparam logic [SW-1:0] CMAX = SW'({CW{1'b1}});

    logic [W-1:0]  bus_q, bus_d;
    logic          inv_q, inv_d;
    logic          inc_q, inc_d;
    logic          sel_q, sel_d;
    logic          vld_q, vld_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          prio_q, prio_d;
    logic [W-1:0]  last_q, last_d;
    logic          hist_q, hist_d;

    logic [W-1:0]  nxt_addr;
    logic [HW-1:0] ham;
    logic [TW-1:0] tog;
    logic [SW-1:0] sum;

    assign nxt_addr = last_q + STEP;

    // Grant the priority channel on contention, else whoever is valid.
    always_comb begin
        a_ready = a_valid && (!d_valid || prio_q == CH_ADDR);
        d_ready = d_valid && (!a_valid || prio_q == CH_DATA);
    end

    hamdist #(.N(W)) u_inv_dist (
        .a_i    (d_data),
        .b_i    (bus_q),
        .dist_o (ham)
    );

    hamdist #(.N(W + 2)) u_tog_dist (
        .a_i    ({bus_d, inv_d, inc_d}),
        .b_i    ({bus_q, inv_q, inc_q}),
        .dist_o (tog)
    );

    // Next bus state, encoder choice and arbitration history.
    always_comb begin
        bus_d  = bus_q;
        inv_d  = inv_q;
        inc_d  = 1'b0;
        sel_d  = sel_q;
        vld_d  = 1'b0;
        prio_d = prio_q;
        last_d = last_q;
        hist_d = hist_q;
        if (a_ready) begin
            vld_d  = 1'b1;
            sel_d  = CH_ADDR;
            inv_d  = 1'b0;
            if (hist_q && a_data == nxt_addr) begin
                inc_d = 1'b1;
            end else begin
                bus_d = a_data;
            end
            last_d = a_data;
            hist_d = 1'b1;
            prio_d = CH_DATA;
        end else if (d_ready) begin
            vld_d  = 1'b1;
            sel_d  = CH_DATA;
            if (ham > HALF) begin
                bus_d = ~d_data;
                inv_d = 1'b1;
            end else begin
                bus_d = d_data;
                inv_d = 1'b0;
            end
            prio_d = CH_ADDR;
        end
    end

    // Saturating accumulation of line toggles, with synchronous clear.
    always_comb begin
        sum = SW'(cnt_q) + SW'(tog);
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (sum > CMAX) begin
            cnt_d = '1;
        end else begin
            cnt_d = sum[CW-1:0];
        end
    end

    // All bus registers and arbiter state.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            bus_q  <= '0;
            inv_q  <= 1'b0;
            inc_q  <= 1'b0;
            sel_q  <= 1'b0;
            vld_q  <= 1'b0;
            cnt_q  <= '0;
            prio_q <= CH_ADDR;
            last_q <= '0;
            hist_q <= 1'b0;
        end else begin
            bus_q  <= bus_d;
            inv_q  <= inv_d;
            inc_q  <= inc_d;
            sel_q  <= sel_d;
            vld_q  <= vld_d;
            cnt_q  <= cnt_d;
            prio_q <= prio_d;
            last_q <= last_d;
            hist_q <= hist_d;
        end
    end

    assign bus       = bus_q;
    assign bus_inv   = inv_q;
    assign bus_inc   = inc_q;
    assign bus_sel   = sel_q;
    assign bus_vld   = vld_q;
    assign trans_cnt = cnt_q;

endmodule

// File: tb/tb_busarb_encctl.sv
// Bench for busarb_encctl: directed traffic, reference model,
// and a per-cycle compare against a 16-bit and a 4-bit counter instance.
module tb_busarb_encctl;

    logic       ck;
    logic       rst;
    logic       a_valid, d_valid, clr_cnt;
    logic [7:0] a_data, d_data;

    logic        a_ready, d_ready;
    logic [7:0]  bus;
    logic        bus_inv, bus_inc, bus_sel, bus_vld;
    logic [15:0] trans_cnt;

    logic        a_ready2, d_ready2;
    logic [7:0]  bus2;
    logic        bus_inv2, bus_inc2, bus_sel2, bus_vld2;
    logic [3:0]  trans_cnt2;

    int checks = 0;
    int errors = 0;
    bit mon_on = 0;

    busarb_encctl #(.W(8), .CW(16), .STRIDE(1)) dut (
        .ck(ck), .rst(rst),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .d_valid(d_valid), .d_data(d_data), .d_ready(d_ready),
        .bus(bus), .bus_inv(bus_inv), .bus_inc(bus_inc),
        .bus_sel(bus_sel), .bus_vld(bus_vld),
        .clr_cnt(clr_cnt), .trans_cnt(trans_cnt)
    );

    busarb_encctl #(.W(8), .CW(4), .STRIDE(1)) dut4 (
        .ck(ck), .rst(rst),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready2),
        .d_valid(d_valid), .d_data(d_data), .d_ready(d_ready2),
        .bus(bus2), .bus_inv(bus_inv2), .bus_inc(bus_inc2),
        .bus_sel(bus_sel2), .bus_vld(bus_vld2),
        .clr_cnt(clr_cnt), .trans_cnt(trans_cnt2)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    typedef struct {
        logic [7:0] bus;
        logic       inv;
        logic       inc;
        logic       sel;
        logic       vld;
        int         cnt;
        logic       prio_data;
        logic [7:0] last;
        logic       hist;
    } mstate_t;

    mstate_t m1, m2;

    function automatic mstate_t mreset();
        mstate_t s;
        s.bus = 8'h00; s.inv = 0; s.inc = 0; s.sel = 0; s.vld = 0;
        s.cnt = 0; s.prio_data = 0; s.last = 8'h00; s.hist = 0;
        return s;
    endfunction

    function automatic logic grant_a(mstate_t s, logic av, logic dv);
        return av && (!dv || !s.prio_data);
    endfunction

    function automatic logic grant_d(mstate_t s, logic av, logic dv);
        return dv && !grant_a(s, av, dv);
    endfunction

    // One clock of the bus rules: grant, encode, count toggles.
    function automatic mstate_t mstep(mstate_t s, logic av,
                                      logic [7:0] ad, logic dv,
                                      logic [7:0] dd, logic clr,
                                      int cap);
        mstate_t n;
        int h, t, acc;
        logic [7:0] seq;
        n = s;
        n.inc = 0;
        n.vld = 0;
        seq = s.last + 8'd1;
        if (grant_a(s, av, dv)) begin
            n.vld = 1; n.sel = 0; n.inv = 0;
            if (s.hist && ad == seq) n.inc = 1;
            else n.bus = ad;
            n.last = ad; n.hist = 1; n.prio_data = 1;
        end else if (grant_d(s, av, dv)) begin
            h = $countones(dd ^ s.bus);
            n.vld = 1; n.sel = 1;
            if (h > 4) begin n.bus = ~dd; n.inv = 1; end
            else begin n.bus = dd; n.inv = 0; end
            n.prio_data = 0;
        end
        t = $countones({n.bus, n.inv, n.inc} ^ {s.bus, s.inv, s.inc});
        acc = s.cnt + t;
        n.cnt = clr ? 0 : (acc > cap ? cap : acc);
        return n;
    endfunction

    always @(posedge ck or negedge rst) begin
        if (!rst) begin
            m1 <= mreset();
            m2 <= mreset();
        end else begin
            m1 <= mstep(m1, a_valid, a_data, d_valid, d_data, clr_cnt, 65535);
            m2 <= mstep(m2, a_valid, a_data, d_valid, d_data, clr_cnt, 15);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every cycle, all observable outputs against the model.
    always @(negedge ck) begin
        if (mon_on) begin
            chk("m_bus", {24'b0, bus}, {24'b0, m1.bus});
            chk("m_flags", {27'b0, bus_inv, bus_inc, bus_sel, bus_vld, 1'b0},
                {27'b0, m1.inv, m1.inc, m1.sel, m1.vld, 1'b0});
            chk("m_cnt", {16'b0, trans_cnt}, m1.cnt);
            chk("m_rdy", {30'b0, a_ready, d_ready},
                {30'b0, grant_a(m1, a_valid, d_valid),
                 grant_d(m1, a_valid, d_valid)});
            chk("m_cnt4", {28'b0, trans_cnt2}, m2.cnt);
            chk("m_bus4", {24'b0, bus2}, {24'b0, m2.bus});
        end
    end

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        step();
        #2 rst = 1'b1;
    endtask

    int na, nd, nboth;

    initial begin
        rst = 1'b0;
        a_valid = 0; d_valid = 0; clr_cnt = 0;
        a_data = 8'h00; d_data = 8'h00;
        step();
        mon_on = 1;
        step();
        chk("rst_bus", {24'b0, bus}, 32'h0);
        chk("rst_cnt", {16'b0, trans_cnt}, 32'h0);
        chk("rst_vld", {31'b0, bus_vld}, 32'h0);
        #2 rst = 1'b1;

        a_valid = 1; a_data = 8'h10;
        step();
        chk("t0_b1_bus", {24'b0, bus}, 32'h10);
        chk("t0_b1_inc", {31'b0, bus_inc}, 32'h0);
        a_data = 8'h11;
        step();
        chk("t0_b2_bus", {24'b0, bus}, 32'h10);
        chk("t0_b2_inc", {31'b0, bus_inc}, 32'h1);
        a_data = 8'h12;
        step();
        chk("t0_b3_bus", {24'b0, bus}, 32'h10);
        chk("t0_b3_inc", {31'b0, bus_inc}, 32'h1);
        chk("t0_cnt", {16'b0, trans_cnt}, 32'd2);
        a_valid = 0;
        step();
        chk("t0_idle_inc", {31'b0, bus_inc}, 32'h0);
        chk("t0_idle_cnt", {16'b0, trans_cnt}, 32'd3);

        a_valid = 1; a_data = 8'hFF;
        step();
        chk("wrap_ff_bus", {24'b0, bus}, 32'hFF);
        a_data = 8'h00;
        step();
        chk("wrap_00_bus", {24'b0, bus}, 32'hFF);
        chk("wrap_00_inc", {31'b0, bus_inc}, 32'h1);

        a_data = 8'h55;
        step();
        #2 rst = 1'b0;
        #1;
        chk("arst_bus", {24'b0, bus}, 32'h0);
        chk("arst_flags", {29'b0, bus_inv, bus_inc, bus_vld}, 32'h0);
        chk("arst_cnt", {16'b0, trans_cnt}, 32'h0);
        step();
        #2 rst = 1'b1;
        a_data = 8'h41;
        step();
        chk("post_rst_bus", {24'b0, bus}, 32'h41);
        chk("post_rst_inc", {31'b0, bus_inc}, 32'h0);
        a_valid = 0;

        do_reset();
        d_valid = 1; d_data = 8'hFF;
        step();
        chk("bi_ff_bus", {24'b0, bus}, 32'h00);
        chk("bi_ff_inv", {31'b0, bus_inv}, 32'h1);
        chk("bi_ff_cnt", {16'b0, trans_cnt}, 32'd1);
        d_data = 8'h0F;
        step();
        chk("bi_tie_bus", {24'b0, bus}, 32'h0F);
        chk("bi_tie_inv", {31'b0, bus_inv}, 32'h0);
        chk("bi_cnt", {16'b0, trans_cnt}, 32'd6);
        d_valid = 0;

        a_valid = 1; a_data = 8'hA5; clr_cnt = 1;
        step();
        chk("clr_bus", {24'b0, bus}, 32'hA5);
        chk("clr_cnt", {16'b0, trans_cnt}, 32'd0);
        chk("clr_cnt4", {28'b0, trans_cnt2}, 32'd0);
        a_valid = 0; clr_cnt = 0;

        do_reset();
        a_valid = 1; a_data = 8'h30;
        d_valid = 1; d_data = 8'hC3;
        na = 0; nd = 0; nboth = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            na += int'(a_ready);
            nd += int'(d_ready);
            nboth += int'(a_ready && d_ready);
            step();
            chk("arb_sel", {31'b0, bus_sel}, i % 2);
        end
        chk("arb_na", na, 3);
        chk("arb_nd", nd, 3);
        chk("arb_both", nboth, 0);
        a_valid = 0; d_valid = 0;

        clr_cnt = 1;
        step();
        clr_cnt = 0;
        d_valid = 1;
        for (int i = 0; i < 20; i++) begin
            d_data = (i % 2 == 0) ? 8'hFF : 8'h00;
            step();
        end
        d_valid = 0;
        chk("sat_cnt4", {28'b0, trans_cnt2}, 32'd15);
        step();
        chk("sat_hold4", {28'b0, trans_cnt2}, 32'd15);

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/busarb_encctl.md
Name: busarb_encctl

Overview:
- Arbitrates one shared, encoded, low-power bus between two requesters: an address stream and a data stream.
- Sequences the encoding applied to each granted transfer:
  - T0 (increment-freeze) for address transfers.
  - Bus-invert for data transfers.
- Accumulates a running count of line transitions on the physical bus, so the encoder variants can be compared under the same traffic in the power-analysis benches.

Parameters:
- W, 8, payload and bus width (even, ≥2).
- CW, 16, width of the transition counter.
- STRIDE, 1, address increment recognised as sequential by T0.

Ports:
- ck, input, 1: single clock; all state updates on posedge.
- rst, input, 1: asynchronous, active-low reset (rst=0 resets immediately, independent of ck).
- a_valid, input, 1: address requester has a word.
- a_data, input, W: address word.
- a_ready, output, 1: address word accepted this cycle (combinational).
- d_valid, input, 1: data requester has a word.
- d_data, input, W: data word.
- d_ready, output, 1: data word accepted this cycle (combinational).
- bus, output, W: registered physical bus lines.
- bus_inv, output, 1: registered; bus carries inverted data.
- bus_inc, output, 1: registered; receiver increments its address by STRIDE, bus lines frozen.
- bus_sel, output, 1: registered; 0 = address beat, 1 = data beat.
- bus_vld, output, 1: registered; a beat is on the bus this cycle.
- clr_cnt, input, 1: synchronous clear of trans_cnt.
- trans_cnt, output, CW: saturating accumulated toggle count over {bus, bus_inv, bus_inc}.

Behaviour:
- Reset (rst=0, asynchronous): all outputs registered 0, prio=ADDR, last_addr=0, addr_hist=0.
- Handshake: valid/ready. A transfer occurs at a posedge where x_valid && x_ready. A requester holds valid and data stable until ready.
- Arbitration (combinational ready, at most one ready per cycle):
  - Both valid: grant prio.
  - One valid: grant it.
  - None valid: no grant.
  - After any grant, prio := the other channel.
  - ready is never asserted without the matching valid.
- Latency: the beat appears on the bus registers one cycle after the accepting edge; throughput is 1 beat/cycle.
- Address beat (bus_sel=1'b0, bus_vld=1):
  - If addr_hist=1 and a_data == last_addr+STRIDE (mod 2^W): bus holds its current value (whatever channel last drove it), bus_inc=1.
  - Otherwise: bus=a_data, bus_inc=0.
  - In both cases bus_inv=0, last_addr:=a_data, addr_hist:=1.
- Data beat (bus_sel=1, bus_vld=1, bus_inc=0):
  - H = Hamming distance(d_data, current bus lines).
  - If H > W/2: bus = ~d_data, bus_inv=1.
  - Otherwise (including H == W/2): bus = d_data, bus_inv=0.
  - Data beats do not alter last_addr or addr_hist.
- Idle cycle: bus and bus_inv hold; bus_inc=0; bus_vld=0; bus_sel holds.
- Counter: each edge, t = popcount(next{bus,bus_inv,bus_inc} XOR current{...}).
  - trans_cnt := min(trans_cnt+t, 2^CW-1).
  - clr_cnt=1 forces trans_cnt:=0 that edge and discards that edge's t.
- Arithmetic: address compare is modulo 2^W, so 0xFF→0x00 with STRIDE=1 is sequential.
- Reset mid-transfer: the pending beat is lost; the requester sees no ready and must re-present. The first address after reset is always sent plain.

Decomposition:
- Shared package busenc_pkg holds:
  - Channel encoding constants CH_ADDR=0, CH_DATA=1.
  - Default W/CW.
  - Function popcount.
- One sub-module, hamdist (parameter N): combinational N-bit XOR+popcount. It is instanced twice:
  - Bus-invert decision, N=W.
  - Toggle counting, N=W+2.

Test Plan:
- Reset check: drive traffic, pull rst low between edges → bus, bus_inv, bus_inc, bus_vld, trans_cnt read 0 before the next edge; after release, a_data=0x41 is sent plain (bus=0x41, bus_inc=0).
- T0 sequence: address only, a_data 0x10, 0x11, 0x12 after reset →
  - beats: bus=0x10/inc=0; bus=0x10/inc=1; bus=0x10/inc=1;
  - trans_cnt=2.
- T0 wrap: addresses 0xFF then 0x00 → second beat bus_inc=1, bus unchanged at 0xFF.
- Bus-invert, from bus=0x00 inv=0:
  - d=0xFF → bus=0x00, inv=1, t=1.
  - then d=0x0F (H=4, tie) → bus=0x0F, inv=0, t=5.
  - trans_cnt=6.
- Arbitration: a_valid and d_valid held high with distinct words for 6 cycles after reset → bus_sel sequence 0,1,0,1,0,1; each ready asserted exactly 3 times, never together.
- Counter: clr_cnt=1 on an edge with a toggling transfer → trans_cnt=0 next cycle.
- Saturation: preload via CW=4 instance, drive alternating 0x00/0xFF data → trans_cnt stops at 15.
